// File: rtl/hilo_muldiv_ctl.sv
// HI/LO multiply-accumulate unit: decodes ALUOp/Funct, runs an iterative shift-add
// multiplier (BPC bits per cycle) and owns the architectural HI/LO registers.
module hilo_muldiv_ctl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BPC   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [1:0]       ALUOp,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic [WIDTH-1:0] hilo_rd,
    output logic             hilo_sel,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             illegal,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned N  = WIDTH / BPC;
    localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, WB} state_t;
    typedef enum logic [1:0] {MOP_MULTU, MOP_MADDU, MOP_MSUBU} mop_t;

    state_t           state_q;
    mop_t             op_q;
    mop_t             dec_op;
    logic             dec_mul, dec_mfhi, dec_mflo, dec_mthi, dec_mtlo, dec_unk;
    logic [WIDTH-1:0] hi_q, lo_q, mplier_q;
    logic [PW-1:0]    mcand_q, prod_q, pp_d, prod_d, acc_d;
    logic [CW-1:0]    cnt_q;
    logic             done_q, illegal_q;

    always_comb begin
        dec_mul  = 1'b0;
        dec_mfhi = 1'b0;
        dec_mflo = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        dec_unk  = 1'b0;
        dec_op   = MOP_MULTU;
        case (ALUOp)
            2'b10: begin
                case (Funct)
                    6'd25:   dec_mul  = 1'b1;
                    6'd16:   dec_mfhi = 1'b1;
                    6'd17:   dec_mthi = 1'b1;
                    6'd18:   dec_mflo = 1'b1;
                    6'd19:   dec_mtlo = 1'b1;
                    default: ;
                endcase
            end
            2'b11: begin
                case (Funct)
                    6'd0:    dec_mul = 1'b1;
                    6'd1:    begin dec_mul = 1'b1; dec_op = MOP_MADDU; end
                    6'd5:    begin dec_mul = 1'b1; dec_op = MOP_MSUBU; end
                    default: dec_unk = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    // Multiplicand is pre-shifted each cycle, so the partial product needs no
    // counter-scaled shifter.
    always_comb begin
        pp_d = '0;
        for (int unsigned j = 0; j < BPC; j++) begin
            if (mplier_q[j]) pp_d = pp_d + (mcand_q << j);
        end
        prod_d = prod_q + pp_d;
        case (op_q)
            MOP_MADDU: acc_d = {hi_q, lo_q} + prod_q;
            MOP_MSUBU: acc_d = {hi_q, lo_q} - prod_q;
            default:   acc_d = prod_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            op_q      <= MOP_MULTU;
            hi_q      <= '0;
            lo_q      <= '0;
            mplier_q  <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= valid & dec_unk;
            case (state_q)
                IDLE: begin
                    if (valid && dec_mul) begin
                        mcand_q  <= {{WIDTH{1'b0}}, src_a};
                        mplier_q <= src_b;
                        prod_q   <= '0;
                        cnt_q    <= '0;
                        op_q     <= dec_op;
                        state_q  <= CALC;
                    end else if (valid && dec_mthi) begin
                        hi_q <= src_a;
                    end else if (valid && dec_mtlo) begin
                        lo_q <= src_a;
                    end
                end
                CALC: begin
                    prod_q   <= prod_d;
                    mcand_q  <= mcand_q << BPC;
                    mplier_q <= mplier_q >> BPC;
                    cnt_q    <= cnt_q + CW'(1);
                    if (cnt_q == CW'(N - 1)) state_q <= WB;
                end
                WB: begin
                    {hi_q, lo_q} <= acc_d;
                    done_q       <= 1'b1;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign stall    = valid & busy & (dec_mul | dec_mfhi | dec_mflo | dec_mthi | dec_mtlo);
    assign hilo_sel = valid & (dec_mfhi | dec_mflo);
    assign hilo_rd  = dec_mfhi ? hi_q : lo_q;
    assign done     = done_q;
    assign illegal  = illegal_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_ctl.sv
// Scoreboard bench for hilo_muldiv_ctl: a 32-bit/BPC=1 instance driven against a
// 64-bit HI/LO model, plus a 16-bit/BPC=4 instance for the parameter sweep.
module tb_hilo_muldiv_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a, b, hilo_rd, hi, lo;
    logic        hilo_sel, stall, busy, done, illegal;

    logic        v16;
    logic [1:0]  op16;
    logic [5:0]  f16;
    logic [15:0] a16, b16, rd16, hi16, lo16;
    logic        sel16, stall16, busy16, done16, ill16;

    hilo_muldiv_ctl #(.WIDTH(32), .BPC(1)) u_dut (
        .clk(clk), .rst(rst), .valid(valid), .ALUOp(aluop), .Funct(funct),
        .src_a(a), .src_b(b), .hilo_rd(hilo_rd), .hilo_sel(hilo_sel),
        .stall(stall), .busy(busy), .done(done), .illegal(illegal),
        .hi(hi), .lo(lo)
    );

    hilo_muldiv_ctl #(.WIDTH(16), .BPC(4)) u_dut16 (
        .clk(clk), .rst(rst), .valid(v16), .ALUOp(op16), .Funct(f16),
        .src_a(a16), .src_b(b16), .hilo_rd(rd16), .hilo_sel(sel16),
        .stall(stall16), .busy(busy16), .done(done16), .illegal(ill16),
        .hi(hi16), .lo(lo16)
    );

    int unsigned n_chk = 0;
    int unsigned n_err = 0;
    logic [63:0] sb[$];
    logic [63:0] model;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_pop(input string tag);
        if (sb.size() == 0) check({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
        else                check(tag, {hi, lo}, sb.pop_front());
    endtask

    task automatic issue_mul(input int kind, input logic [31:0] ia, input logic [31:0] ib);
        logic [63:0] p;
        p = 64'(ia) * 64'(ib);
        case (kind)
            1:       model = model + p;
            2:       model = model - p;
            default: model = p;
        endcase
        sb.push_back(model);
        case (kind)
            1:       begin aluop = 2'b11; funct = 6'd1;  end
            2:       begin aluop = 2'b11; funct = 6'd5;  end
            3:       begin aluop = 2'b11; funct = 6'd0;  end
            default: begin aluop = 2'b10; funct = 6'd25; end
        endcase
        valid = 1'b1; a = ia; b = ib;
        tick();
        valid = 1'b0; aluop = 2'b00; funct = 6'd0;
    endtask

    task automatic wait_done(input string tag, input int unsigned maxc,
                             output int unsigned cyc, output int unsigned bcyc);
        cyc = 0; bcyc = 0;
        while (!done && cyc < maxc) begin
            if (busy) bcyc++;
            tick();
            cyc++;
        end
        if (done) sb_pop(tag);
    endtask

    task automatic run_mul(input string tag, input int kind, input logic [31:0] ia, input logic [31:0] ib);
        int unsigned cyc, bcyc;
        issue_mul(kind, ia, ib);
        wait_done(tag, 100, cyc, bcyc);
        check({tag, "_latency"}, 64'(cyc), 64'd33);
        check({tag, "_busy"}, 64'(bcyc), 64'd33);
    endtask

    task automatic move(input logic to_hi, input logic [31:0] d);
        valid = 1'b1; aluop = 2'b10; funct = to_hi ? 6'd17 : 6'd19; a = d;
        tick();
        valid = 1'b0; aluop = 2'b00; funct = 6'd0;
        if (to_hi) model[63:32] = d;
        else       model[31:0]  = d;
        check(to_hi ? "mthi" : "mtlo", {hi, lo}, model);
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int unsigned cyc, sc, bc, dn;
        logic [63:0] prev;
        valid = 0; aluop = 0; funct = 0; a = 0; b = 0;
        v16 = 0; op16 = 0; f16 = 0; a16 = 0; b16 = 0;
        model = '0;

        repeat (2) tick();
        rst = 1'b0;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);

        run_mul("multu_max", 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_max_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_max_lo", 64'(lo), 64'h0000_0001);
        tick();
        check("done_one_cycle", 64'(done), 64'd0);

        move(1'b1, 32'h0);
        move(1'b0, 32'hFFFF_FFFF);
        run_mul("maddu", 1, 32'd1, 32'd1);
        check("maddu_val", {hi, lo}, 64'h0000_0001_0000_0000);
        run_mul("msubu_b2b", 2, 32'd2, 32'd1);
        check("msubu_val", {hi, lo}, 64'h0000_0000_FFFF_FFFE);

        // mfhi presented the cycle after a multu must stall until done
        issue_mul(0, 32'd3, 32'd5);
        valid = 1'b1; aluop = 2'b10; funct = 6'd16;
        cyc = 0; sc = 0;
        while (!done && cyc < 100) begin
            #1;
            if (stall) sc++;
            tick();
            cyc++;
        end
        #1;
        check("mfhi_stall_cycles", 64'(sc), 64'd33);
        check("mfhi_stall_released", 64'(stall), 64'd0);
        check("mfhi_sel", 64'(hilo_sel), 64'd1);
        check("mfhi_rd", 64'(hilo_rd), 64'd0);
        if (done) sb_pop("mul_3x5");
        funct = 6'd18;
        #1;
        check("mflo_rd", 64'(hilo_rd), 64'd15);
        check("mflo_stall", 64'(stall), 64'd0);
        tick();
        valid = 1'b0; aluop = 2'b00; funct = 6'd0;

        for (int i = 0; i < 6; i++) begin
            run_mul("rand_mul", int'($urandom_range(0, 3)), $urandom, $urandom);
        end

        valid = 1'b1; aluop = 2'b11; funct = 6'd63;
        tick();
        valid = 1'b0;
        check("illegal_pulse", 64'(illegal), 64'd1);
        tick();
        check("illegal_clear", 64'(illegal), 64'd0);
        check("illegal_hilo", {hi, lo}, model);
        valid = 1'b1; aluop = 2'b10; funct = 6'd63;
        tick();
        valid = 1'b0;
        check("rtype_no_illegal", 64'(illegal), 64'd0);
        tick();
        check("rtype_no_illegal2", 64'(illegal), 64'd0);
        check("rtype_hilo", {hi, lo}, model);
        aluop = 2'b00; funct = 6'd0;

        prev = model;
        issue_mul(0, 32'd7, 32'd9);
        repeat (5) tick();
        check("calc_hold", {hi, lo}, prev);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        model = '0;
        check("midcalc_rst_hilo", {hi, lo}, 64'd0);
        check("midcalc_rst_busy", 64'(busy), 64'd0);
        dn = 0; bc = 0;
        repeat (40) begin
            if (done) dn++;
            if (busy) bc++;
            tick();
        end
        check("midcalc_no_done", 64'(dn), 64'd0);
        check("midcalc_no_busy", 64'(bc), 64'd0);

        v16 = 1'b1; op16 = 2'b10; f16 = 6'd25; a16 = 16'h1234; b16 = 16'hABCD;
        tick();
        f16 = 6'd32;
        #1;
        check("w16_add_no_stall", 64'(stall16), 64'd0);
        check("w16_calc_hold", {32'd0, hi16, lo16}, 64'd0);
        f16 = 6'd16;
        #1;
        check("w16_mfhi_stall", 64'(stall16), 64'd1);
        v16 = 1'b0; op16 = 2'b00; f16 = 6'd0;
        cyc = 0; bc = 0;
        while (!done16 && cyc < 50) begin
            if (busy16) bc++;
            tick();
            cyc++;
        end
        check("w16_latency", 64'(cyc), 64'd5);
        check("w16_busy", 64'(bc), 64'd5);
        check("w16_hi", 64'(hi16), 64'h0C37);
        check("w16_lo", 64'(lo16), 64'h4FA4);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
